// File: rtl/cache_def_pkg.sv
// Shared widths, record types and FSM states for the direct-mapped cache controller.
package cache_def_pkg;

  localparam int unsigned CacheAddrW  = 32;
  localparam int unsigned CacheIndexW = 10;
  localparam int unsigned CacheTagW   = 18;
  localparam int unsigned CacheLineW  = 128;
  localparam int unsigned CacheCntW   = 32;
  localparam int unsigned CacheWordW  = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [CacheTagW-1:0] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [CacheIndexW-1:0] index;
    logic                   we;
  } cache_req_type;

  typedef logic [CacheLineW-1:0] cache_data_type;

  typedef struct packed {
    logic                  valid;
    logic                  rw;
    logic [CacheAddrW-1:0] addr;
    logic [CacheWordW-1:0] data;
  } cpu_req_type;

  typedef struct packed {
    logic                  ready;
    logic [CacheWordW-1:0] data;
  } cpu_result_type;

  typedef struct packed {
    logic                  valid;
    logic                  rw;
    logic [CacheAddrW-1:0] addr;
    cache_data_type        data;
  } mem_req_type;

  typedef struct packed {
    logic           ready;
    cache_data_type data;
  } mem_data_type;

  typedef enum logic [1:0] {StIdle, StCompareTag, StAllocate, StWriteBack} cache_state_e;

endpackage

// File: rtl/dm_cache_ctrl.sv
// Blocking FSM for a direct-mapped write-back, write-allocate cache with
// external tag/data stores (combinational read, registered write).
module dm_cache_ctrl
  import cache_def_pkg::*;
#(
  parameter int unsigned ADDR_W  = CacheAddrW,
  parameter int unsigned INDEX_W = CacheIndexW,
  parameter int unsigned TAG_W   = CacheTagW,
  parameter int unsigned LINE_W  = CacheLineW,
  parameter int unsigned CNT_W   = CacheCntW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req_valid,
  input  logic               cpu_req_rw,
  input  logic [ADDR_W-1:0]  cpu_req_addr,
  input  logic [31:0]        cpu_req_data,
  output logic               cpu_res_ready,
  output logic [31:0]        cpu_res_data,
  output logic               mem_req_valid,
  output logic               mem_req_rw,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic [LINE_W-1:0]  mem_req_data,
  input  logic               mem_data_ready,
  input  logic [LINE_W-1:0]  mem_data_data,
  output logic [INDEX_W-1:0] tag_req_index,
  output logic               tag_req_we,
  output logic [TAG_W+1:0]   tag_write,
  input  logic [TAG_W+1:0]   tag_read,
  output logic [INDEX_W-1:0] data_req_index,
  output logic               data_req_we,
  output logic [LINE_W-1:0]  data_write,
  input  logic [LINE_W-1:0]  data_read,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  cache_state_e     state_q, state_d;
  cpu_req_type      req_q, req_d;
  logic             missed_q, missed_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  cache_tag_type      tag_rd;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [6:0]         lane_base;
  logic               hit;
  logic               tag_we, data_we;

  assign tag_rd    = cache_tag_type'(tag_read);
  assign req_index = req_q.addr[INDEX_W+3:4];
  assign req_tag   = req_q.addr[ADDR_W-1:INDEX_W+4];
  assign lane_base = {req_q.addr[3:2], 5'd0};
  assign hit       = tag_rd.valid && (tag_rd.tag == req_tag);

  assign tag_req_index  = (state_q == StIdle) ? cpu_req_addr[INDEX_W+3:4] : req_index;
  assign data_req_index = tag_req_index;
  // Store writes are suppressed while reset is asserted so an abandoned fill leaves no trace.
  assign tag_req_we     = tag_we & ~rst;
  assign data_req_we    = data_we & ~rst;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_q.valid, req_q.addr[1:0], cpu_req_addr[1:0]};

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    missed_d      = missed_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    cpu_res_ready = 1'b0;
    cpu_res_data  = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    tag_we        = 1'b0;
    tag_write     = '0;
    data_we       = 1'b0;
    data_write    = '0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req_valid) begin
          req_d    = '{valid: 1'b1, rw: cpu_req_rw, addr: cpu_req_addr, data: cpu_req_data};
          missed_d = 1'b0;
          state_d  = StCompareTag;
        end
      end
      StCompareTag: begin
        if (hit) begin
          cpu_res_ready = 1'b1;
          if (!missed_q && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
          if (req_q.rw) begin
            data_we                      = 1'b1;
            data_write                   = data_read;
            data_write[lane_base +: 32]  = req_q.data;
            tag_we                       = 1'b1;
            tag_write                    = {1'b1, 1'b1, req_tag};
          end else begin
            cpu_res_data = data_read[lane_base +: 32];
          end
          state_d = StIdle;
        end else begin
          if (!missed_q && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
          missed_d = 1'b1;
          state_d  = (tag_rd.valid && tag_rd.dirty) ? StWriteBack : StAllocate;
        end
      end
      StWriteBack: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_rd.tag, req_index, 4'h0};
        mem_req_data  = data_read;
        if (mem_data_ready) state_d = StAllocate;
      end
      StAllocate: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index, 4'h0};
        if (mem_data_ready) begin
          data_we    = 1'b1;
          data_write = mem_data_data;
          tag_we     = 1'b1;
          tag_write  = {1'b1, 1'b0, req_tag};
          state_d    = StCompareTag;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= '0;
      missed_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      missed_q   <= missed_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule
